// File: rtl/bopit_round_ctrl.sv
// Bop-It round sequencer: issues one-hot commands, times the response window in
// divider ticks, scores hits and shrinks the window after each one.
module bopit_round_ctrl #(
    parameter int NUM_CMDS    = 3,
    parameter int INIT_WINDOW = 20,
    parameter int MIN_WINDOW  = 6,
    parameter int WINDOW_STEP = 1,
    parameter int GAP_TICKS   = 4,
    parameter int WIN_SCORE   = 99
) (
    input  logic                masterclk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                start,
    input  logic [NUM_CMDS-1:0] action_in,
    input  logic [1:0]          rand_in,
    output logic [NUM_CMDS-1:0] cmd,
    output logic                cmd_valid,
    output logic [7:0]          time_left,
    output logic [7:0]          score,
    output logic                hit_pulse,
    output logic                game_over,
    output logic                win
);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_ISSUE, S_WAIT, S_HIT, S_OVER
    } state_t;

    localparam logic [7:0] INIT8  = 8'(INIT_WINDOW);
    localparam logic [7:0] MIN8   = 8'(MIN_WINDOW);
    localparam logic [7:0] STEP8  = 8'(WINDOW_STEP);
    localparam logic [7:0] GAP8   = 8'(GAP_TICKS);
    localparam logic [7:0] WIN8   = 8'(WIN_SCORE);
    localparam logic [8:0] FLOOR9 = 9'(MIN_WINDOW + WINDOW_STEP);

    state_t              r_state, w_next;
    logic                r_tick_prev;
    logic [NUM_CMDS-1:0] r_action_prev;
    logic [NUM_CMDS-1:0] r_cmd;
    logic [7:0]          r_time_left;
    logic [7:0]          r_score;
    logic [7:0]          r_window;
    logic [7:0]          r_gap_cnt;
    logic                r_win;

    logic                w_tick_ev;
    logic [NUM_CMDS-1:0] w_rise;
    logic                w_wrong;
    logic                w_correct;
    logic [7:0]          w_score_inc;
    logic                w_win_hit;
    logic [7:0]          w_window_next;
    logic [1:0]          w_idx;
    logic [NUM_CMDS-1:0] w_cmd_sel;

    assign w_tick_ev   = tick_in & ~r_tick_prev;
    assign w_rise      = action_in & ~r_action_prev;
    // Any stray rise, even alongside the right one, loses the round.
    assign w_wrong     = (w_rise != '0) && (w_rise != r_cmd);
    assign w_correct   = (w_rise == r_cmd) && (r_cmd != '0);
    assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_win_hit   = (w_score_inc == WIN8);
    // Compare in 9 bits so the subtraction can never wrap below the floor.
    assign w_window_next = ({1'b0, r_window} >= FLOOR9) ? (r_window - STEP8) : MIN8;
    assign w_idx       = (32'(rand_in) < NUM_CMDS) ? rand_in : 2'd0;
    assign w_cmd_sel   = NUM_CMDS'(1) << w_idx;

    always_ff @(posedge masterclk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_GAP;
            S_GAP:   if (w_tick_ev && r_gap_cnt <= 8'd1) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_wrong)                                w_next = S_OVER;
                else if (w_correct)                         w_next = S_HIT;
                else if (w_tick_ev && r_time_left <= 8'd1)  w_next = S_OVER;
            end
            S_HIT:   w_next = w_win_hit ? S_OVER : S_GAP;
            S_OVER:  if (start) w_next = S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            r_tick_prev   <= 1'b0;
            r_action_prev <= '0;
            r_cmd         <= '0;
            r_time_left   <= 8'd0;
            r_score       <= 8'd0;
            r_window      <= INIT8;
            r_gap_cnt     <= 8'd0;
            r_win         <= 1'b0;
        end else begin
            r_tick_prev   <= tick_in;
            r_action_prev <= action_in;
            unique case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_score   <= 8'd0;
                        r_window  <= INIT8;
                        r_gap_cnt <= GAP8;
                        r_win     <= 1'b0;
                    end
                end
                S_GAP: if (w_tick_ev) r_gap_cnt <= r_gap_cnt - 8'd1;
                S_ISSUE: begin
                    r_cmd       <= w_cmd_sel;
                    r_time_left <= r_window;
                end
                S_WAIT: begin
                    // A correct press wins over a simultaneous tick; a wrong one freezes time_left.
                    if (!w_wrong && !w_correct && w_tick_ev && r_time_left != 8'd0)
                        r_time_left <= r_time_left - 8'd1;
                end
                S_HIT: begin
                    r_score   <= w_score_inc;
                    r_window  <= w_window_next;
                    r_gap_cnt <= GAP8;
                    if (w_win_hit) r_win <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd       = (r_state == S_WAIT) ? r_cmd : '0;
    assign cmd_valid = (r_state == S_WAIT);
    assign hit_pulse = (r_state == S_HIT);
    assign game_over = (r_state == S_OVER);
    assign win       = r_win;
    assign time_left = r_time_left;
    assign score     = r_score;

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// Randomized game-level checks of bopit_round_ctrl against a round/score/window model.
module tb_bopit_round_ctrl;

    logic       masterclk = 1'b0;
    logic       rst       = 1'b1;
    logic       tick_in   = 1'b0;
    logic       start     = 1'b0;
    logic [2:0] action_in = 3'b000;
    logic [1:0] rand_in   = 2'd0;

    logic [2:0] cmd       [2];
    logic       cmd_valid [2];
    logic [7:0] time_left [2];
    logic [7:0] score     [2];
    logic       hit_pulse [2];
    logic       game_over [2];
    logic       win       [2];

    int n_chk  = 0;
    int n_fail = 0;

    int p_init [2] = '{20, 7};
    int p_min  [2] = '{6, 6};
    int p_step [2] = '{1, 2};
    int p_win  [2] = '{99, 3};

    int         m_score;
    int         m_window;
    int         m_tl;
    logic [2:0] m_cmd;

    always #5 masterclk = ~masterclk;

    bopit_round_ctrl #(.NUM_CMDS(3), .INIT_WINDOW(20), .MIN_WINDOW(6), .WINDOW_STEP(1),
                       .GAP_TICKS(4), .WIN_SCORE(99)) u_dut0 (
        .masterclk(masterclk), .rst(rst), .tick_in(tick_in), .start(start),
        .action_in(action_in), .rand_in(rand_in), .cmd(cmd[0]), .cmd_valid(cmd_valid[0]),
        .time_left(time_left[0]), .score(score[0]), .hit_pulse(hit_pulse[0]),
        .game_over(game_over[0]), .win(win[0]));

    bopit_round_ctrl #(.NUM_CMDS(3), .INIT_WINDOW(7), .MIN_WINDOW(6), .WINDOW_STEP(2),
                       .GAP_TICKS(4), .WIN_SCORE(3)) u_dut1 (
        .masterclk(masterclk), .rst(rst), .tick_in(tick_in), .start(start),
        .action_in(action_in), .rand_in(rand_in), .cmd(cmd[1]), .cmd_valid(cmd_valid[1]),
        .time_left(time_left[1]), .score(score[1]), .hit_pulse(hit_pulse[1]),
        .game_over(game_over[1]), .win(win[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge masterclk);
        #1;
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk({tag, "_cmd"},   cmd[d], 0);
        chk({tag, "_valid"}, cmd_valid[d], 0);
        chk({tag, "_tl"},    time_left[d], 0);
        chk({tag, "_score"}, score[d], 0);
        chk({tag, "_hit"},   hit_pulse[d], 0);
        chk({tag, "_over"},  game_over[d], 0);
        chk({tag, "_win"},   win[d], 0);
    endtask

    task automatic start_game(input int d);
        start = 1'b1;
        step();
        start = 1'b0;
        m_score  = 0;
        m_window = p_init[d];
        chk("start_over",  game_over[d], 0);
        chk("start_score", score[d], 0);
        chk("start_valid", cmd_valid[d], 0);
    endtask

    // GAP_TICKS ticks, the command appearing two cycles after the last one.
    task automatic run_gap(input int d, input int r, input bit mid_start);
        rand_in = 2'(r);
        for (int i = 1; i < 4; i++) begin
            do_tick();
            chk("gap_cmd",   cmd[d], 0);
            chk("gap_valid", cmd_valid[d], 0);
            if (mid_start && i == 2) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        tick_in = 1'b1;
        step();
        chk("issue_valid", cmd_valid[d], 0);
        tick_in = 1'b0;
        step();
        m_cmd = 3'b001 << ((r < 3) ? r : 0);
        m_tl  = m_window;
        chk("wait_valid", cmd_valid[d], 1);
        chk("wait_cmd",   cmd[d], m_cmd);
        chk("wait_tl",    time_left[d], m_tl);
    endtask

    task automatic wait_ticks(input int d, input int k);
        for (int i = 0; i < k; i++) begin
            do_tick();
            m_tl--;
            chk("count_tl", time_left[d], m_tl);
            if (m_tl == 0) chk("timeout_over", game_over[d], 1);
            else           chk("count_valid", cmd_valid[d], 1);
        end
    endtask

    task automatic model_hit(input int d);
        if (m_score < 255) m_score++;
        m_window = m_window - p_step[d];
        if (m_window < p_min[d]) m_window = p_min[d];
    endtask

    task automatic press_hit(input int d);
        action_in = m_cmd;
        step();
        chk("hit_pulse", hit_pulse[d], 1);
        chk("hit_cmd",   cmd[d], 0);
        chk("hit_valid", cmd_valid[d], 0);
        action_in = 3'b000;
        model_hit(d);
        step();
        chk("hit_score",   score[d], m_score);
        chk("hit_pulse_1", hit_pulse[d], 0);
        if (m_score == p_win[d]) begin
            chk("win_over", game_over[d], 1);
            chk("win_flag", win[d], 1);
        end else begin
            chk("hit_over", game_over[d], 0);
        end
    endtask

    initial begin
        int r;
        int guard;
        logic [2:0] wrong;

        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk_all_zero(0, "rst0");
        chk_all_zero(1, "rst1");
        rst = 1'b0;
        do_tick();
        chk("idle_stays", cmd_valid[0], 0);
        chk("idle_over",  game_over[0], 0);

        // first round, rand_in=1, then a hit shrinking the window
        start_game(0);
        run_gap(0, 1, 1'b0);
        chk("first_cmd", cmd[0], 3'b010);
        press_hit(0);
        chk("window_19", m_window, 19);

        // rand_in=3 falls back to command 0; start mid-gap ignored
        run_gap(0, 3, 1'b1);

        // timeout
        wait_ticks(0, m_tl);
        chk("to_win",   win[0], 0);
        chk("to_score", score[0], 1);
        chk("to_tl",    time_left[0], 0);

        // wrong button
        start_game(0);
        run_gap(0, $urandom_range(0, 3), 1'b0);
        wait_ticks(0, $urandom_range(0, 5));
        wrong = {m_cmd[1:0], m_cmd[2]};
        action_in = wrong;
        step();
        chk("wrong_over",  game_over[0], 1);
        chk("wrong_win",   win[0], 0);
        chk("wrong_tl",    time_left[0], m_tl);
        chk("wrong_score", score[0], 0);
        action_in = 3'b000;
        step();

        // correct plus wrong together
        start_game(0);
        run_gap(0, $urandom_range(0, 3), 1'b0);
        wrong = {m_cmd[1:0], m_cmd[2]};
        action_in = m_cmd | wrong;
        step();
        chk("both_over", game_over[0], 1);
        chk("both_hit",  hit_pulse[0], 0);
        chk("both_win",  win[0], 0);
        action_in = 3'b000;
        step();

        // correct press on the same cycle as the final tick
        start_game(0);
        run_gap(0, $urandom_range(0, 3), 1'b0);
        wait_ticks(0, m_tl - 1);
        tick_in   = 1'b1;
        action_in = m_cmd;
        step();
        chk("race_hit",  hit_pulse[0], 1);
        chk("race_over", game_over[0], 0);
        tick_in   = 1'b0;
        action_in = 3'b000;
        model_hit(0);
        step();
        chk("race_score", score[0], m_score);

        // buttons held into WAIT are not a response
        action_in = 3'b111;
        run_gap(0, $urandom_range(0, 3), 1'b0);
        step();
        chk("held_hit",   hit_pulse[0], 0);
        chk("held_valid", cmd_valid[0], 1);
        action_in = 3'b000;
        step();
        press_hit(0);

        // reset mid-round
        run_gap(0, $urandom_range(0, 3), 1'b0);
        rst = 1'b1;
        step();
        chk_all_zero(0, "midrst");
        rst = 1'b0;
        repeat (5) do_tick();
        chk("post_rst_idle", cmd_valid[0], 0);

        // randomized full game to a win
        start_game(0);
        guard = 0;
        while (m_score < p_win[0] && guard < 200) begin
            r = $urandom_range(0, 3);
            run_gap(0, r, ($urandom_range(0, 3) == 0));
            wait_ticks(0, $urandom_range(0, m_window - 1));
            press_hit(0);
            guard++;
        end
        chk("game_score", score[0], 99);
        chk("game_win",   win[0], 1);

        // short game: window floor and WIN_SCORE=3
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start_game(1);
        for (int i = 0; i < 3; i++) begin
            run_gap(1, $urandom_range(0, 3), 1'b0);
            wait_ticks(1, $urandom_range(0, m_tl - 1));
            press_hit(1);
        end
        chk("short_score", score[1], 3);
        chk("short_win",   win[1], 1);
        chk("short_over",  game_over[1], 1);
        chk("short_floor", m_window, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
